message_rx: RTL and testbench

MESSAGE_RX -- requirements
Module: message_rx

---
 rtl/msg_rx_pkg.sv | 24 ++
 rtl/msg_bit_correlator.sv | 99 +++++++++
 rtl/message_rx.sv | 134 +++++++++++++
 tb/tb_message_rx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_rx_pkg.sv
// Shared definitions for the spread-spectrum message receiver: FSM encoding,
// accumulator sizing and message word packing.
package msg_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } msg_rx_state_e;

    localparam int WORD_W    = 32;
    localparam int MAX_WORDS = 4;

    // Sample width plus growth over one full bit integration, plus a sign guard.
    function automatic int acc_width(input int sample_w, input int pcode_len,
                                     input int pcode_repeats);
        return sample_w + $clog2(pcode_len * pcode_repeats) + 1;
    endfunction

    function automatic int msg_words(input int message_len);
        return (message_len + WORD_W - 1) / WORD_W;
    endfunction

endpackage

// File: rtl/msg_bit_correlator.sv
// Walks the code ROM one chip per valid sample and correlates samples against
// the code over PCODE_REPEATS periods, emitting one decided bit per integration.
module msg_bit_correlator
    import msg_rx_pkg::*;
#(
    parameter int PCODE_LEN     = 40920,
    parameter int PCODE_REPEATS = 10,
    parameter int SAMPLE_W      = 12,
    localparam int ACC_W        = acc_width(SAMPLE_W, PCODE_LEN, PCODE_REPEATS),
    localparam int AW           = (PCODE_LEN > 1) ? $clog2(PCODE_LEN) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       run,
    input  logic                       adc_valid,
    input  logic signed [SAMPLE_W-1:0] adc_data,
    output logic [AW-1:0]              pcode_addr,
    input  logic                       pcode_chip,
    input  logic [ACC_W-1:0]           weak_thresh,
    output logic                       bit_valid,
    output logic                       bit_value,
    output logic                       bit_weak
);

    localparam int RW = (PCODE_REPEATS > 1) ? $clog2(PCODE_REPEATS) : 1;

    logic [AW-1:0]              chip_cnt;
    logic [RW-1:0]              rep_cnt;
    logic                       chip_wrap;
    logic                       rep_wrap;
    logic                       d_valid;
    logic                       d_last;
    logic signed [SAMPLE_W-1:0] d_data;
    logic signed [ACC_W-1:0]    d_ext;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic [ACC_W-1:0]           acc_mag;

    assign chip_wrap  = (chip_cnt == AW'(PCODE_LEN - 1));
    assign rep_wrap   = (rep_cnt == RW'(PCODE_REPEATS - 1));
    assign pcode_addr = chip_cnt;

    // ROM data arrives one cycle after its address, so the sample waits one cycle to meet it.
    assign d_ext    = {{(ACC_W - SAMPLE_W){d_data[SAMPLE_W-1]}}, d_data};
    assign acc_next = pcode_chip ? (acc + d_ext) : (acc - d_ext);
    assign acc_mag  = acc_next[ACC_W-1] ? $unsigned(-acc_next) : $unsigned(acc_next);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chip_cnt <= '0;
            rep_cnt  <= '0;
            d_valid  <= 1'b0;
            d_last   <= 1'b0;
            d_data   <= '0;
        end else if (start) begin
            chip_cnt <= '0;
            rep_cnt  <= '0;
            d_valid  <= 1'b0;
            d_last   <= 1'b0;
        end else begin
            d_valid <= run && adc_valid;
            d_data  <= adc_data;
            d_last  <= chip_wrap && rep_wrap;
            if (run && adc_valid) begin
                if (chip_wrap) begin
                    chip_cnt <= '0;
                    rep_cnt  <= rep_wrap ? '0 : rep_cnt + RW'(1);
                end else begin
                    chip_cnt <= chip_cnt + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            bit_valid <= 1'b0;
            bit_value <= 1'b0;
            bit_weak  <= 1'b0;
        end else if (start) begin
            acc       <= '0;
            bit_valid <= 1'b0;
        end else begin
            bit_valid <= d_valid && d_last;
            if (d_valid) begin
                if (d_last) begin
                    acc       <= '0;
                    bit_value <= !acc_next[ACC_W-1] && (acc_next != '0);
                    bit_weak  <= (acc_mag < weak_thresh);
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

endmodule

// File: rtl/message_rx.sv
// Message receiver: frames on sys_pps, collects MESSAGE_LEN correlated bits into
// a shadow buffer and publishes them to a word-readable buffer when complete.
module message_rx
    import msg_rx_pkg::*;
#(
    parameter int PCODE_LEN     = 40920,
    parameter int PCODE_REPEATS = 10,
    parameter int MESSAGE_LEN   = 120,
    parameter int SAMPLE_W      = 12,
    localparam int ACC_W        = acc_width(SAMPLE_W, PCODE_LEN, PCODE_REPEATS),
    localparam int AW           = (PCODE_LEN > 1) ? $clog2(PCODE_LEN) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sys_pps,
    input  logic                       adc_valid,
    input  logic signed [SAMPLE_W-1:0] adc_data,
    output logic [AW-1:0]              pcode_addr,
    input  logic                       pcode_chip,
    input  logic [ACC_W-1:0]           weak_thresh,
    input  logic [1:0]                 msg_rd_addr,
    output logic [31:0]                msg_rd_data,
    output logic                       msg_done,
    output logic                       msg_weak,
    output logic                       resync,
    output logic                       busy,
    output msg_rx_state_e              state_dbg
);

    localparam int NWORDS = msg_words(MESSAGE_LEN);

    msg_rx_state_e                     state;
    msg_rx_state_e                     state_next;
    logic                              start;
    logic                              run;
    logic                              take_bit;
    logic                              copy;
    logic                              last_bit;
    logic                              rd_in_range;
    logic [6:0]                        bit_cnt;
    logic                              weak_any;
    logic [MAX_WORDS-1:0][WORD_W-1:0]  shadow;
    logic [MAX_WORDS-1:0][WORD_W-1:0]  rd_buf;
    logic                              bit_valid;
    logic                              bit_value;
    logic                              bit_weak;

    // adc_valid is a one-cycle strobe with no backpressure: a sample is consumed
    // on every clk edge where adc_valid is high while the receiver is running.
    msg_bit_correlator #(
        .PCODE_LEN    (PCODE_LEN),
        .PCODE_REPEATS(PCODE_REPEATS),
        .SAMPLE_W     (SAMPLE_W)
    ) u_corr (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .run        (run),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .pcode_addr (pcode_addr),
        .pcode_chip (pcode_chip),
        .weak_thresh(weak_thresh),
        .bit_valid  (bit_valid),
        .bit_value  (bit_value),
        .bit_weak   (bit_weak)
    );

    assign last_bit    = (bit_cnt == 7'(MESSAGE_LEN - 1));
    assign rd_in_range = ({1'b0, msg_rd_addr} < 3'(NWORDS));
    assign state_dbg   = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (sys_pps) state_next = ST_RUN;
            ST_RUN: begin
                if (sys_pps)                    state_next = ST_RUN;
                else if (bit_valid && last_bit) state_next = ST_DONE;
            end
            ST_DONE: state_next = sys_pps ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ST_RUN);
        start    = sys_pps;
        run      = busy && !sys_pps;
        take_bit = run && bit_valid;
        copy     = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt     <= '0;
            weak_any    <= 1'b0;
            shadow      <= '0;
            rd_buf      <= '0;
            msg_done    <= 1'b0;
            msg_weak    <= 1'b0;
            resync      <= 1'b0;
            msg_rd_data <= '0;
        end else begin
            msg_done <= copy;
            if (start) begin
                bit_cnt  <= '0;
                weak_any <= 1'b0;
                shadow   <= '0;
            end else if (take_bit) begin
                bit_cnt                             <= bit_cnt + 7'd1;
                weak_any                            <= weak_any | bit_weak;
                shadow[bit_cnt[6:5]][~bit_cnt[4:0]] <= bit_value;
            end
            if (copy) begin
                rd_buf   <= shadow;
                msg_weak <= weak_any;
                resync   <= 1'b0;
            end else if (sys_pps && busy) begin
                resync <= 1'b1;
            end
            // Bypass from shadow so a read landing in the msg_done cycle sees the new message.
            if (!rd_in_range) msg_rd_data <= '0;
            else if (copy)    msg_rd_data <= shadow[msg_rd_addr];
            else              msg_rd_data <= rd_buf[msg_rd_addr];
        end
    end

endmodule

// File: tb/tb_message_rx.sv
// Randomized bench for message_rx: a per-bit correlation-sum model predicts every
// decided message, and a negedge compare process checks read data and flags.
module tb_message_rx;
    import msg_rx_pkg::*;

    localparam int L     = 8;
    localparam int R     = 2;
    localparam int ML    = 40;
    localparam int SW    = 12;
    localparam int AWT   = 3;
    localparam int ACCT  = 17;
    localparam int NSAMP = L * R * ML;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 sys_pps = 1'b0;
    logic                 adc_valid = 1'b0;
    logic signed [SW-1:0] adc_data = '0;
    logic [AWT-1:0]       pcode_addr;
    logic                 pcode_chip = 1'b0;
    logic [ACCT-1:0]      weak_thresh = '0;
    logic [1:0]           msg_rd_addr = '0;
    logic [31:0]          msg_rd_data;
    logic                 msg_done;
    logic                 msg_weak;
    logic                 resync;
    logic                 busy;
    msg_rx_state_e        state_dbg;

    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    logic [128:0] exp_q[$];
    logic [128:0] cmp_e;
    logic [127:0] model_buf = '0;
    logic         model_weak = 1'b0;
    logic         model_resync = 1'b0;
    logic [1:0]   addr_d = '0;
    logic [L-1:0] code = 8'b1011_0010;

    message_rx #(
        .PCODE_LEN    (L),
        .PCODE_REPEATS(R),
        .MESSAGE_LEN  (ML),
        .SAMPLE_W     (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sys_pps    (sys_pps),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .pcode_addr (pcode_addr),
        .pcode_chip (pcode_chip),
        .weak_thresh(weak_thresh),
        .msg_rd_addr(msg_rd_addr),
        .msg_rd_data(msg_rd_data),
        .msg_done   (msg_done),
        .msg_weak   (msg_weak),
        .resync     (resync),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock/reset environment and code ROM with one cycle of read latency.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) pcode_chip <= code[pcode_addr];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: read data, msg_weak and resync checked against the model every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            model_buf    = '0;
            model_weak   = 1'b0;
            model_resync = 1'b0;
        end else begin
            if (msg_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 128'(msg_done), 128'(0));
                end else begin
                    cmp_e      = exp_q.pop_front();
                    model_buf  = cmp_e[127:0];
                    model_weak = cmp_e[128];
                end
                model_resync = 1'b0;
                done_cnt++;
                done_cyc = cyc;
            end
            check("msg_rd_data", 128'(msg_rd_data), 128'(model_buf[32*addr_d +: 32]));
            check("msg_weak", 128'(msg_weak), 128'(model_weak));
            check("resync", 128'(resync), 128'(model_resync));
        end
        addr_d = msg_rd_addr;
    end

    // abort_kind: 0 none, 1 sys_pps at sample abort_at, 2 reset at sample abort_at.
    task automatic run_msg(input logic [ML-1:0] msg, input int amp, input int noise,
                           input int vmode, input int abort_kind, input int abort_at,
                           input logic [ACCT-1:0] thr, output logic [127:0] words,
                           output logic weak_o, output int latency);
        int   sum[ML];
        int   n, k, s, chip, t, target, pps_cyc, ph, mag;
        logic v;
        bit   aborted;
        weak_thresh = thr;
        words       = '0;
        weak_o      = 1'b0;
        latency     = -1;
        sys_pps     = 1'b1;
        adc_valid   = 1'b0;
        pps_cyc     = cyc;
        tick();
        sys_pps = 1'b0;
        for (int i = 0; i < ML; i++) sum[i] = 0;
        n       = 0;
        ph      = 0;
        s       = 0;
        aborted = 1'b0;
        while (n < NSAMP) begin
            if (!aborted && abort_kind == 1 && n == abort_at) begin
                sys_pps   = 1'b1;
                adc_valid = 1'b0;
                pps_cyc   = cyc;
                tick();
                sys_pps      = 1'b0;
                model_resync = 1'b1;
                @(negedge clk);
                check("abort_resync_set", 128'(resync), 128'(1));
                check("abort_no_done", 128'(msg_done), 128'(0));
                tick();
                for (int i = 0; i < ML; i++) sum[i] = 0;
                n       = 0;
                aborted = 1'b1;
                continue;
            end
            if (!aborted && abort_kind == 2 && n == abort_at) begin
                adc_valid = 1'b0;
                #2 rst = 1'b0;
                #1;
                check("rst_mid_busy", 128'(busy), 128'(0));
                check("rst_mid_done", 128'(msg_done), 128'(0));
                check("rst_mid_weak", 128'(msg_weak), 128'(0));
                check("rst_mid_resync", 128'(resync), 128'(0));
                check("rst_mid_addr", 128'(pcode_addr), 128'(0));
                check("rst_mid_rdata", 128'(msg_rd_data), 128'(0));
                tick();
                tick();
                rst = 1'b1;
                tick();
                return;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (ph % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            ph++;
            chip      = n % L;
            k         = n / (L * R);
            adc_valid = v;
            if (v) begin
                s = code[chip] ? amp : -amp;
                if (!msg[ML-1-k]) s = -s;
                if (noise > 0) s += int'($urandom_range(0, 2 * noise)) - noise;
                adc_data = SW'(s);
            end else begin
                adc_data = SW'($urandom_range(0, 4095));
            end
            msg_rd_addr = 2'($urandom_range(0, 3));
            @(negedge clk);
            check("pcode_addr", 128'(pcode_addr), 128'(chip));
            check("busy_run", 128'(busy), 128'(1));
            tick();
            if (v) begin
                sum[k] += code[chip] ? s : -s;
                n++;
            end
        end
        adc_valid = 1'b0;
        for (int i = 0; i < ML; i++) begin
            words[32 * (i / 32) + 31 - (i % 32)] = (sum[i] > 0);
            mag = (sum[i] < 0) ? -sum[i] : sum[i];
            if (mag < int'(thr)) weak_o = 1'b1;
        end
        exp_q.push_back({weak_o, words});
        target = done_cnt + 1;
        t      = 0;
        while (done_cnt < target && t < 60) begin
            msg_rd_addr = 2'($urandom_range(0, 3));
            tick();
            t++;
        end
        check("done_seen", 128'(done_cnt), 128'(target));
        latency = done_cyc - pps_cyc - 1;
        repeat (3) begin
            msg_rd_addr = 2'($urandom_range(0, 3));
            tick();
        end
    endtask

    task automatic read_word(input logic [1:0] a, input logic [31:0] expv, input string name);
        msg_rd_addr = a;
        tick();
        @(negedge clk);
        check(name, 128'(msg_rd_data), 128'(expv));
        tick();
    endtask

    initial begin
        logic [127:0] w;
        logic         wk;
        int           lat;
        rst = 1'b0;
        repeat (3) tick();
        check("rst_state", 128'(state_dbg), 128'(ST_IDLE));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(msg_done), 128'(0));
        check("rst_weak", 128'(msg_weak), 128'(0));
        check("rst_resync", 128'(resync), 128'(0));
        check("rst_addr", 128'(pcode_addr), 128'(0));
        check("rst_rdata", 128'(msg_rd_data), 128'(0));
        rst = 1'b1;
        repeat (2) tick();

        // Clean message, continuous samples.
        run_msg(40'hA5A5A5A55A, 100, 0, 0, 0, -1, 17'd50, w, wk, lat);
        check("t1_model_w0", w[31:0], 32'hA5A5A5A5);
        check("t1_model_w1", w[63:32], 32'h5A000000);
        check("t1_model_weak", 128'(wk), 128'(0));
        check("t1_latency_ok", 128'(lat >= 641 && lat <= 648), 128'(1));
        read_word(2'd0, 32'hA5A5A5A5, "t1_w0");
        read_word(2'd1, 32'h5A000000, "t1_w1");
        read_word(2'd2, 32'h0, "t1_w2");
        read_word(2'd3, 32'h0, "t1_w3");

        // Inverted samples.
        run_msg(~40'hA5A5A5A55A, 100, 0, 0, 0, -1, 17'd50, w, wk, lat);
        read_word(2'd0, 32'h5A5A5A5A, "t2_w0");
        read_word(2'd1, 32'hA5000000, "t2_w1");

        // All-zero samples: every bit is 0, weak depends on threshold.
        run_msg(40'hA5A5A5A55A, 0, 0, 0, 0, -1, 17'd1, w, wk, lat);
        check("t3_model_weak", 128'(wk), 128'(1));
        check("t3_weak", 128'(msg_weak), 128'(1));
        read_word(2'd0, 32'h0, "t3_w0");
        read_word(2'd1, 32'h0, "t3_w1");
        run_msg(40'hA5A5A5A55A, 0, 0, 0, 0, -1, 17'd0, w, wk, lat);
        check("t3b_weak", 128'(msg_weak), 128'(0));

        // One valid in three.
        run_msg(40'hA5A5A5A55A, 100, 0, 1, 0, -1, 17'd50, w, wk, lat);
        read_word(2'd0, 32'hA5A5A5A5, "t4_w0");
        read_word(2'd1, 32'h5A000000, "t4_w1");
        check("t4_weak", 128'(msg_weak), 128'(0));

        // Resync at bit 20, then a full message.
        run_msg(40'h123456789A, 100, 0, 0, 1, 20 * L * R, 17'd50, w, wk, lat);
        read_word(2'd0, 32'h12345678, "t5_w0");
        read_word(2'd1, 32'h9A000000, "t5_w1");
        check("t5_resync_clear", 128'(resync), 128'(0));

        // Random messages with noise and random gaps.
        for (int r = 0; r < 6; r++) begin
            run_msg({$urandom, 8'($urandom)}, int'($urandom_range(0, 30)),
                    int'($urandom_range(0, 150)), 2, 0, -1,
                    17'($urandom_range(0, 400)), w, wk, lat);
        end

        // Reset in the middle of a message.
        run_msg({$urandom, 8'($urandom)}, 100, 0, 0, 2, 200, 17'd50, w, wk, lat);
        read_word(2'd0, 32'h0, "t7_w0");
        read_word(2'd1, 32'h0, "t7_w1");
        check("t7_weak", 128'(msg_weak), 128'(0));
        check("t7_resync", 128'(resync), 128'(0));

        run_msg({$urandom, 8'($urandom)}, 20, 100, 0, 0, -1, 17'd200, w, wk, lat);

        check("exp_q_empty", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
